adpcm_mc: RTL

Multi-channel IMA ADPCM codec. It encodes 16-bit PCM to 4-bit codes or decodes 4-bit codes to PCM, chosen per transaction. Each channel keeps its own predictor and step-index state in register arrays, so one datapath time-shares CH independent streams. It sits between the audio sample mux and the packet framer, replacing the single-channel codec where more than one stream is active.

---
 rtl/adpcm_mc.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/adpcm_mc.sv
// rtl/adpcm_mc.sv - multi-channel IMA ADPCM encoder/decoder with per-channel predictor state
//
// One shared bit-serial datapath processes one request at a time. Each channel
// keeps its own predictor and step index, so CH independent streams can share it.
// A request is accepted in IDLE, takes LOAD, B2, B1, B0 and UPD, and its result
// is then held in OUT until out_ready.
//
// Optional feature macro: ADPCM_MC_CLIP_FLAG_EN
//   defined   - clip is registered at UPD, high when the predictor was saturated
//   undefined - clip is tied low (saturation itself is always performed)
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   enable             synchronous enable; low forces IDLE and clears state/outputs
//   in_valid/in_ready  request handshake (in_ready high only in IDLE)
//   in_mode            1 = decode, 0 = encode
//   in_ch              channel id of the request
//   in_pcm             PCM sample to encode
//   in_code            ADPCM code to decode
//   out_valid/out_ready result handshake
//   out_ch             channel of the result
//   out_pcm            reconstructed predictor
//   out_code           produced (encode) or echoed (decode) code
//   clip               predictor saturated on this result
//   clr, clr_ch        clear one channel's predictor and step index
module adpcm_mc #(
    parameter int CH  = 4,
    parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [CHW-1:0]     in_ch,
    input  logic signed [15:0] in_pcm,
    input  logic [3:0]         in_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHW-1:0]     out_ch,
    output logic signed [15:0] out_pcm,
    output logic [3:0]         out_code,
    output logic               clip,
    input  logic               clr,
    input  logic [CHW-1:0]     clr_ch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_B2,
        S_B1,
        S_B0,
        S_UPD,
        S_OUT
    } state_t;

    localparam logic [CHW:0] CH_L = CH[CHW:0];

    localparam int STEP_TAB [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    state_t state_q, state_d;

    // per-channel state
    logic [15:0] pred_arr_q [CH];
    logic [6:0]  idx_arr_q  [CH];

    // in-flight transaction
    logic           mode_q, mode_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           chok_q, chok_d;
    logic [15:0]    pcm_q, pcm_d;
    logic [3:0]     code_q, code_d;
    logic [14:0]    step_q, step_d;
    logic [16:0]    vp_q, vp_d;
    logic [16:0]    mag_q, mag_d;
    logic [15:0]    pred_q, pred_d;
    logic [6:0]     idxl_q, idxl_d;

    // result registers
    logic [CHW-1:0] out_ch_q;
    logic [15:0]    out_pcm_q;
    logic [3:0]     out_code_q;

    // channel state read at LOAD; out-of-range ids read channel 0 harmlessly
    logic [CHW-1:0] rd_ch;
    logic [15:0]    pred_rd;
    logic [6:0]     idx_rd;
    logic [14:0]    step_rd;
    logic [16:0]    diff_w;

    assign rd_ch   = chok_q ? ch_q : '0;
    assign pred_rd = pred_arr_q[rd_ch];
    assign idx_rd  = idx_arr_q[rd_ch];
    assign step_rd = STEP_TAB[idx_rd][14:0];
    assign diff_w  = {pcm_q[15], pcm_q} - {pred_rd[15], pred_rd};

    // successive-approximation step for the current bit state
    logic [16:0] s_cur;
    logic [1:0]  bit_k;

    always_comb begin
        s_cur = '0;
        bit_k = 2'd0;
        case (state_q)
            S_B2: begin s_cur = {2'b00, step_q};        bit_k = 2'd2; end
            S_B1: begin s_cur = {3'b000, step_q[14:1]}; bit_k = 2'd1; end
            S_B0: begin s_cur = {4'b0000, step_q[14:2]}; bit_k = 2'd0; end
            default: ;
        endcase
    end

    // predictor update: 18-bit sum, saturate by checking the two guard bits
    logic [17:0] p18;
    logic        sat_hi, sat_lo;
    logic [15:0] p_w;
    logic [7:0]  adj8;
    logic [7:0]  idx_sum;
    logic [6:0]  idx_new;

    always_comb begin
        p18 = code_q[3] ? ({{2{pred_q[15]}}, pred_q} - {1'b0, vp_q})
                        : ({{2{pred_q[15]}}, pred_q} + {1'b0, vp_q});
        sat_hi = !p18[17] && (p18[16:15] != 2'b00);
        sat_lo =  p18[17] && (p18[16:15] != 2'b11);
        p_w = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : p18[15:0]);
        // adjust is -1 for magnitudes 0..3, else 2*(code[1:0]+1)
        adj8 = code_q[2] ? ({5'b00000, code_q[1:0], 1'b0} + 8'd2) : 8'hFF;
        idx_sum = {1'b0, idxl_q} + adj8;
        idx_new = idx_sum[7] ? 7'd0 : ((idx_sum[6:0] > 7'd88) ? 7'd88 : idx_sum[6:0]);
    end

    // FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUT);
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_d = S_LOAD;
                S_LOAD:  state_d = S_B2;
                S_B2:    state_d = S_B1;
                S_B1:    state_d = S_B0;
                S_B0:    state_d = S_UPD;
                S_UPD:   state_d = S_OUT;
                S_OUT:   if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // datapath next-state
    always_comb begin
        mode_d = mode_q;
        ch_d   = ch_q;
        chok_d = chok_q;
        pcm_d  = pcm_q;
        code_d = code_q;
        step_d = step_q;
        vp_d   = vp_q;
        mag_d  = mag_q;
        pred_d = pred_q;
        idxl_d = idxl_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d = in_mode;
                    ch_d   = in_ch;
                    chok_d = ({1'b0, in_ch} < CH_L);
                    pcm_d  = in_pcm;
                    code_d = in_code;
                end
            end
            S_LOAD: begin
                step_d = step_rd;
                vp_d   = {5'b00000, step_rd[14:3]};
                pred_d = pred_rd;
                idxl_d = idx_rd;
                if (!mode_q) begin
                    // encode builds the code from scratch; bit 3 carries the sign
                    code_d = {diff_w[16], 3'b000};
                    mag_d  = diff_w[16] ? (17'd0 - diff_w) : diff_w;
                end
            end
            S_B2, S_B1, S_B0: begin
                if (!mode_q) begin
                    if (mag_q >= s_cur) begin
                        code_d[bit_k] = 1'b1;
                        mag_d = mag_q - s_cur;
                        vp_d  = vp_q + s_cur;
                    end
                end else if (code_q[bit_k]) begin
                    vp_d = vp_q + s_cur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q <= 1'b0;
            ch_q   <= '0;
            chok_q <= 1'b0;
            pcm_q  <= '0;
            code_q <= '0;
            step_q <= '0;
            vp_q   <= '0;
            mag_q  <= '0;
            pred_q <= '0;
            idxl_q <= '0;
        end else begin
            mode_q <= mode_d;
            ch_q   <= ch_d;
            chok_q <= chok_d;
            pcm_q  <= pcm_d;
            code_q <= code_d;
            step_q <= step_d;
            vp_q   <= vp_d;
            mag_q  <= mag_d;
            pred_q <= pred_d;
            idxl_q <= idxl_d;
        end
    end

    // channel state: the clear is applied after the write-back so it wins on a tie
    logic wr_en, clr_en;
    assign wr_en  = (state_q == S_UPD) && chok_q;
    assign clr_en = clr && ({1'b0, clr_ch} < CH_L);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CH; i++) begin
                pred_arr_q[i] <= '0;
                idx_arr_q[i]  <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < CH; i++) begin
                pred_arr_q[i] <= '0;
                idx_arr_q[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                pred_arr_q[ch_q] <= p_w;
                idx_arr_q[ch_q]  <= idx_new;
            end
            if (clr_en) begin
                pred_arr_q[clr_ch] <= '0;
                idx_arr_q[clr_ch]  <= '0;
            end
        end
    end

    // result registers, loaded only at UPD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_ch_q   <= '0;
            out_pcm_q  <= '0;
            out_code_q <= '0;
        end else if (!enable) begin
            out_ch_q   <= '0;
            out_pcm_q  <= '0;
            out_code_q <= '0;
        end else if (state_q == S_UPD) begin
            out_ch_q   <= ch_q;
            out_pcm_q  <= chok_q ? p_w : 16'h0000;
            out_code_q <= chok_q ? code_q : 4'h0;
        end
    end

    assign out_ch   = out_ch_q;
    assign out_pcm  = out_pcm_q;
    assign out_code = out_code_q;

`ifdef ADPCM_MC_CLIP_FLAG_EN
    logic clip_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clip_q <= 1'b0;
        end else if (!enable) begin
            clip_q <= 1'b0;
        end else if (state_q == S_UPD) begin
            clip_q <= chok_q && (sat_hi || sat_lo);
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

endmodule
